// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave cook control FSM with power duty cycling and end beep
module cook_sequencer #(
  parameter int PWR_PERIOD = 10,
  parameter int BEEP_SECS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       zero,
  input  logic [3:0] power_level,
  output logic       timer_enable,
  output logic       timer_clear,
  output logic       mag_on,
  output logic       beep,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  state_t state_q, state_d;
  logic start_q, stop_q, clear_q;
  logic start_ev, stop_ev, clear_ev;
  logic [3:0] pwr_q, pwr_d, phase_q, phase_d, bcnt_q, bcnt_d, pwr_eff, pwr_cap;
  logic [4:0] bsum;
  logic timer_enable_q, timer_clear_q, enter_cook, enter_done;
  assign start_ev = start_q & ~startn;
  assign stop_ev  = stop_q & ~stopn;
  assign clear_ev = clear_q & ~clearn;
  assign bsum     = {1'b0, bcnt_q} + {4'd0, tick_1hz};
  // next-state selection with clear > door open > stop > zero > start priority
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = (!clear_ev && start_ev && door_closed && !zero) ? COOK : IDLE;
      COOK:  state_d = clear_ev ? IDLE : (!door_closed || stop_ev) ? PAUSE : zero ? DONE : COOK;
      PAUSE: state_d = (clear_ev || stop_ev) ? IDLE : (start_ev && door_closed) ? COOK : PAUSE;
      DONE:  state_d = (clear_ev || stop_ev || start_ev || !door_closed || bsum >= 5'(BEEP_SECS)) ? IDLE : DONE;
    endcase
  end
  // counters: cleared on state entry, with a coincident tick counted in the new state
  always_comb begin
    enter_cook = state_d == COOK && state_q != COOK;
    enter_done = state_d == DONE && state_q != DONE;
    phase_d = enter_cook ? {3'd0, tick_1hz}
            : (state_q == COOK && tick_1hz) ? (phase_q == 4'(PWR_PERIOD - 1) ? 4'd0 : phase_q + 4'd1)
            : phase_q;
    bcnt_d = enter_done ? {3'd0, tick_1hz} : (state_q == DONE && tick_1hz) ? bcnt_q + 4'd1 : bcnt_q;
    pwr_d = (state_q == IDLE && state_d == COOK) ? power_level : pwr_q;
    pwr_eff = (pwr_q == 4'd0 || pwr_q > 4'd10) ? 4'd10 : pwr_q;
    pwr_cap = pwr_eff > 4'(PWR_PERIOD) ? 4'(PWR_PERIOD) : pwr_eff;
  end
  // state, button history, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      clear_q        <= 1'b0;
      pwr_q          <= 4'd0;
      phase_q        <= 4'd0;
      bcnt_q         <= 4'd0;
      timer_enable_q <= 1'b0;
      timer_clear_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= startn;
      stop_q         <= stopn;
      clear_q        <= clearn;
      pwr_q          <= pwr_d;
      phase_q        <= phase_d;
      bcnt_q         <= bcnt_d;
      timer_enable_q <= state_d == COOK;
      timer_clear_q  <= clear_ev | (state_q == PAUSE && stop_ev);
    end
  end
  assign state        = state_q;
  assign timer_enable = timer_enable_q;
  assign timer_clear  = timer_clear_q;
  assign beep         = state_q == DONE;
  assign mag_on       = (state_q == COOK) && (phase_q < pwr_cap) && door_closed;
endmodule
